// File: rtl/biquad_mac_seq.sv
// Direct form I biquad evaluated with one multiplier over five MAC cycles,
// single rounding and saturation, valid/ready output and owned x/y history.
module biquad_mac_seq #(
  parameter int W     = 16,
  parameter int FRAC  = 15,
  parameter int ACC_W = 2*W+3
) (
  input  logic                Clk1,
  input  logic                Rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] b0,
  input  logic signed [W-1:0] b1,
  input  logic signed [W-1:0] b2,
  input  logic signed [W-1:0] a1,
  input  logic signed [W-1:0] a2,
  input  logic                hist_wr,
  input  logic [1:0]          hist_sel,
  input  logic signed [W-1:0] hist_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] y_out,
  output logic                sat_flag,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] RND   = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  state_t state;
  logic [2:0] k;

  logic signed [W-1:0] x0, x1, x2, y1, y2;
  logic signed [W-1:0] c_b0, c_b1, c_b2, c_a1, c_a2;
  logic signed [ACC_W-1:0] acc;

  logic signed [W-1:0]     coef, data;
  logic signed [2*W-1:0]   coef_ext, data_ext, prod;
  logic signed [ACC_W-1:0] term, acc_f, rounded, shifted;
  logic signed [W-1:0]     y_sat;
  logic                    clip;

  // Term k picks its coefficient/history pair; feedback terms are subtracted.
  always_comb begin
    coef     = '0;
    data     = '0;
    coef_ext = '0;
    data_ext = '0;
    prod     = '0;
    term     = '0;
    acc_f    = '0;
    rounded  = '0;
    shifted  = '0;
    y_sat    = '0;
    clip     = 1'b0;
    case (k)
      3'd0: begin coef = c_b0; data = x0; end
      3'd1: begin coef = c_b1; data = x1; end
      3'd2: begin coef = c_b2; data = x2; end
      3'd3: begin coef = c_a1; data = y1; end
      3'd4: begin coef = c_a2; data = y2; end
      default: begin coef = '0; data = '0; end
    endcase
    coef_ext = {{W{coef[W-1]}}, coef};
    data_ext = {{W{data[W-1]}}, data};
    prod     = coef_ext * data_ext;
    term     = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    if (k >= 3'd3)
      acc_f = acc - term;
    else
      acc_f = acc + term;
    rounded = acc_f + RND;
    shifted = rounded >>> FRAC;
    if (shifted > Y_MAX) begin
      y_sat = Y_MAX[W-1:0];
      clip  = 1'b1;
    end else if (shifted < Y_MIN) begin
      y_sat = Y_MIN[W-1:0];
      clip  = 1'b1;
    end else begin
      y_sat = shifted[W-1:0];
    end
  end

  always_ff @(posedge Clk1 or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      k         <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      y_out     <= '0;
      sat_flag  <= 1'b0;
      acc       <= '0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      c_b0      <= '0;
      c_b1      <= '0;
      c_b2      <= '0;
      c_a1      <= '0;
      c_a2      <= '0;
    end else if (flush) begin
      state     <= IDLE;
      k         <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Preload lands on the accept edge too, so the new sample sees it.
          if (hist_wr) begin
            case (hist_sel)
              2'd0: x1 <= hist_data;
              2'd1: x2 <= hist_data;
              2'd2: y1 <= hist_data;
              default: y2 <= hist_data;
            endcase
          end
          if (in_valid) begin
            x0       <= x_in;
            c_b0     <= b0;
            c_b1     <= b1;
            c_b2     <= b2;
            c_a1     <= a1;
            c_a2     <= a2;
            acc      <= '0;
            k        <= '0;
            state    <= MAC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc_f;
          k   <= k + 3'd1;
          if (k == 3'd4) begin
            y_out     <= y_sat;
            sat_flag  <= clip;
            out_valid <= 1'b1;
            x2        <= x1;
            x1        <= x0;
            y2        <= y1;
            y1        <= y_sat;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_mac_seq.sv
// Directed bench for biquad_mac_seq: a vector table run back to back plus
// hand sequences for reset, preload, saturation, backpressure and flush.
module tb_biquad_mac_seq;

  logic        Clk1 = 1'b0;
  logic        Rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_in, b0, b1, b2, a1, a2;
  logic        hist_wr;
  logic [1:0]  hist_sel;
  logic [15:0] hist_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y_out;
  logic        sat_flag;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  biquad_mac_seq dut (
    .Clk1(Clk1), .Rst(Rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .hist_wr(hist_wr), .hist_sel(hist_sel), .hist_data(hist_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .sat_flag(sat_flag), .busy(busy)
  );

  always #5 Clk1 = ~Clk1;

  typedef struct {
    logic [15:0] b0, b1, b2, a1, a2, x;
    logic [15:0] y;
    logic        sat;
  } vec_t;

  vec_t vt [9];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One sample through the full handshake; coefficient inputs are scrambled
  // right after the accept edge, optionally with hist_wr pulsed during MAC.
  task automatic applyStimulus(input logic [15:0] cb0, cb1, cb2, ca1, ca2, cx,
                               input bit poke_hist,
                               output logic [15:0] y, output logic s, output int lat);
    b0 = cb0; b1 = cb1; b2 = cb2; a1 = ca1; a2 = ca2; x_in = cx;
    in_valid = 1'b1;
    checkOutput("in_ready before accept", in_ready, 1);
    @(posedge Clk1); #1;
    in_valid = 1'b0;
    b0 = 16'h5A5A; b1 = 16'h5A5A; b2 = 16'h5A5A; a1 = 16'h5A5A; a2 = 16'h5A5A; x_in = 16'h5A5A;
    hist_wr = poke_hist;
    if (poke_hist) begin
      hist_sel  = 2'd0;
      hist_data = 16'h3000;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge Clk1); #1;
      lat++;
    end
    hist_wr = 1'b0;
    y = y_out;
    s = sat_flag;
    out_ready = 1'b1;
    @(posedge Clk1); #1;
    out_ready = 1'b0;
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    @(posedge Clk1); #1;
    flush = 1'b0;
  endtask

  initial begin
    logic [15:0] y;
    logic        s;
    int          lat;
    int          bad;

    Rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    hist_wr = 1'b0; hist_sel = '0; hist_data = '0;

    // Feedback impulse, negative-y2 term, rounding ties and history readback.
    vt[0] = '{16'h4000, 16'h0000, 16'h0000, 16'hC000, 16'h0000, 16'h7FFF, 16'h4000, 1'b0};
    vt[1] = '{16'h4000, 16'h0000, 16'h0000, 16'hC000, 16'h0000, 16'h0000, 16'h2000, 1'b0};
    vt[2] = '{16'h4000, 16'h0000, 16'h0000, 16'hC000, 16'h0000, 16'h0000, 16'h1000, 1'b0};
    vt[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'hF800, 1'b0};
    vt[4] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hC000, 16'h0000, 1'b0};
    vt[5] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h0001, 1'b0};
    vt[6] = '{16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4000, 1'b0};
    vt[7] = '{16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'hC000, 1'b0};
    vt[8] = '{16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'hC000, 1'b0};

    #12;
    checkOutput("reset y_out", y_out, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset sat_flag", sat_flag, 0);
    Rst = 1'b0;
    @(posedge Clk1); #1;

    $display("[TB] passthrough");
    applyStimulus(16'h7FFF, 0, 0, 0, 0, 16'h4000, 0, y, s, lat);
    checkOutput("passthrough y", y, 16'h4000);
    checkOutput("passthrough sat", s, 0);
    checkOutput("passthrough latency", lat, 5);
    checkOutput("out_valid after handshake", out_valid, 0);

    $display("[TB] reset mid-MAC");
    b0 = 16'h7FFF; x_in = 16'h1234; in_valid = 1'b1;
    @(posedge Clk1); #1;
    in_valid = 1'b0;
    @(posedge Clk1); #1;
    @(posedge Clk1); #1;
    Rst = 1'b1;
    #2;
    checkOutput("mid reset y_out", y_out, 0);
    checkOutput("mid reset out_valid", out_valid, 0);
    checkOutput("mid reset in_ready", in_ready, 1);
    checkOutput("mid reset busy", busy, 0);
    Rst = 1'b0;
    @(posedge Clk1); #1;
    applyStimulus(0, 16'h7FFF, 0, 16'h8000, 0, 0, 0, y, s, lat);
    checkOutput("history after reset", y, 0);

    $display("[TB] vector table");
    pulseFlush();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vt[i].b0, vt[i].b1, vt[i].b2, vt[i].a1, vt[i].a2, vt[i].x, 0, y, s, lat);
      checkOutput($sformatf("vec%0d y", i), y, vt[i].y);
      checkOutput($sformatf("vec%0d sat", i), s, vt[i].sat);
      checkOutput($sformatf("vec%0d latency", i), lat, 5);
    end

    $display("[TB] saturation");
    pulseFlush();
    hist_wr = 1'b1; hist_sel = 2'd0; hist_data = 16'h7FFF;
    @(posedge Clk1); #1;
    hist_sel = 2'd1; hist_data = 16'h7FFF;
    applyStimulus(16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0, 16'h7FFF, 0, y, s, lat);
    checkOutput("sat pos y", y, 16'h7FFF);
    checkOutput("sat pos flag", s, 1);
    pulseFlush();
    hist_wr = 1'b1; hist_sel = 2'd0; hist_data = 16'h8000;
    @(posedge Clk1); #1;
    hist_sel = 2'd1; hist_data = 16'h8000;
    applyStimulus(16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0, 16'h8000, 0, y, s, lat);
    checkOutput("sat neg y", y, 16'h8000);
    checkOutput("sat neg flag", s, 1);

    $display("[TB] backpressure");
    pulseFlush();
    b0 = 16'h7FFF; b1 = 0; b2 = 0; a1 = 0; a2 = 0; x_in = 16'h4000; in_valid = 1'b1;
    @(posedge Clk1); #1;
    x_in = 16'h1234;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge Clk1); #1;
      lat++;
    end
    checkOutput("bp latency", lat, 5);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk1); #1;
      if (!out_valid || y_out !== 16'h4000 || in_ready || !busy) bad++;
    end
    checkOutput("bp stall cycles unstable", bad, 0);
    checkOutput("bp y held", y_out, 16'h4000);
    out_ready = 1'b1;
    @(posedge Clk1); #1;
    out_ready = 1'b0;
    checkOutput("bp out_valid after handshake", out_valid, 0);
    checkOutput("bp in_ready after handshake", in_ready, 1);
    @(posedge Clk1); #1;
    in_valid = 1'b0;
    checkOutput("bp next accept busy", busy, 1);
    checkOutput("bp next accept in_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge Clk1); #1;
      lat++;
    end
    checkOutput("bp second latency", lat, 5);
    checkOutput("bp second y", y_out, 16'h1234);
    out_ready = 1'b1;
    @(posedge Clk1); #1;
    out_ready = 1'b0;

    $display("[TB] flush mid-MAC");
    b0 = 16'h7FFF; x_in = 16'h1000; in_valid = 1'b1;
    @(posedge Clk1); #1;
    in_valid = 1'b0;
    @(posedge Clk1); #1;
    @(posedge Clk1); #1;
    flush = 1'b1;
    @(posedge Clk1); #1;
    flush = 1'b0;
    checkOutput("flush out_valid", out_valid, 0);
    checkOutput("flush in_ready", in_ready, 1);
    checkOutput("flush busy", busy, 0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk1); #1;
      if (out_valid) bad++;
    end
    checkOutput("flush spurious out_valid", bad, 0);
    applyStimulus(0, 16'h7FFF, 0, 16'h8000, 0, 16'h2000, 1, y, s, lat);
    checkOutput("history after flush", y, 0);
    applyStimulus(0, 16'h7FFF, 0, 0, 0, 0, 0, y, s, lat);
    checkOutput("hist_wr in MAC ignored", y, 16'h2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/biquad_mac_seq.md
# biquad_mac_seq

Sequential, single-multiplier biquad (direct form I) compute stage for the programmable IIR datapath. It accepts one Q1.15 input sample per handshake and evaluates y = b0·x0 + b1·x1 + b2·x2 − a1·y1 − a2·y2 over five multiply-accumulate cycles. The result is rounded once and saturated, then presented on a valid/ready output. It sits between the bus controller, which supplies samples and coefficients, and the write-back path, which consumes y. It owns the x/y history registers.

## Interface
- W, 16, sample/coefficient width (signed, Q1.(W−1))
- FRAC, 15, fractional bits of samples and coefficients
- ACC_W, 2*W+3, accumulator width (guard bits for 5-term sum)
- Clk1  input  1  the block's only clock; all state changes on rising edge
- Rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of history; aborts any computation in progress
- in_valid  input  1  x_in valid
- in_ready  output  1  block can accept a sample (IDLE only)
- x_in  input  W  new sample x0, signed
- b0, b1, b2, a1, a2  input  W each  coefficients, signed Q1.15, sampled at accept
- hist_wr  input  1  history preload strobe (IDLE only)
- hist_sel  input  2  0 = x1, 1 = x2, 2 = y1, 3 = y2
- hist_data  input  W  preload value
- out_valid  output  1  y_out valid
- out_ready  input  1  consumer accepts y_out
- y_out  output  W  filtered sample, signed Q1.15
- sat_flag  output  1  y_out was clipped; qualified by out_valid
- busy  output  1  state ≠ IDLE

## Operation
- States: IDLE, MAC (term counter k = 0..4), OUT.
- IDLE: in_ready = 1. On in_valid && in_ready:
  - latch x_in into x0 and b0..a2 into coefficient registers;
  - clear the accumulator;
  - go to MAC with k = 0.
- MAC, one term per cycle:
  - k0: +b0·x0; k1: +b1·x1; k2: +b2·x2; k3: −a1·y1; k4: −a2·y2.
  - Each product is a full signed 2W-bit product, sign-extended to ACC_W.
  - No per-product rounding.
- Final edge of MAC (k4):
  - acc_f = acc + term4; r = (acc_f + 2^(FRAC−1)) >>> FRAC (arithmetic shift; ties round toward +∞).
  - Saturate r to [−2^(W−1), 2^(W−1)−1].
  - y_out ← saturated r; sat_flag ← (clip occurred); out_valid ← 1.
  - History updates on the same edge: x2 ← x1, x1 ← x0, y2 ← y1, y1 ← saturated y.
  - Go to OUT.
- OUT:
  - y_out, sat_flag and out_valid hold stable until out_valid && out_ready.
  - On that edge: out_valid ← 0, go to IDLE.
- hist_wr in IDLE writes hist_data to the selected register. hist_wr in any other state is ignored.
- hist_wr and an accept in the same IDLE cycle: the preload is written first, so the computation uses the preloaded value.
- flush (any state):
  - x1, x2, y1, y2 ← 0; out_valid ← 0; go to IDLE; no output for an aborted sample.
  - flush has priority over hist_wr and over accept.
- Coefficient input changes after the accept edge do not affect the sample in flight.

## Timing
- Reset values: state = IDLE; in_ready = 1; out_valid = 0; y_out = 0; sat_flag = 0; busy = 0; all history, accumulator and coefficient registers = 0.
- Accept at edge E0; MAC runs on edges E1..E5; out_valid is high after E5. Latency is 5 cycles from the accept edge.
- With out_ready held high: handshake at E6, IDLE after E6, next accept at E7. Maximum throughput is 1 sample per 7 cycles.
- in_ready is a registered function of state (IDLE). It has no combinational path from out_ready.
- Rst asserted mid-computation: immediate return to reset values; the in-flight sample is lost.
- flush at an edge takes effect that edge; in_ready = 1 the following cycle.

## Test plan
- Reset: Rst pulse mid-MAC → y_out = 0x0000, out_valid = 0, in_ready = 1, busy = 0, history reads back as zeros.
- Passthrough: b0 = 0x7FFF, other coefficients 0, x_in = 0x4000 → y_out = 0x4000, sat_flag = 0, out_valid exactly 5 cycles after accept.
- Feedback impulse: b0 = 0x4000, a1 = 0xC000, others 0; inputs 0x7FFF, 0, 0 → y_out = 0x4000, 0x2000, 0x1000.
- Saturation:
  - Positive: b0 = b1 = b2 = 0x7FFF, x1 = x2 = 0x7FFF preloaded via hist_wr, x_in = 0x7FFF → y_out = 0x7FFF, sat_flag = 1.
  - Negative: same coefficients, all x values 0x8000 → y_out = 0x8000, sat_flag = 1.
- Backpressure: out_ready low for 10 cycles, in_valid high throughout → y_out/out_valid stable, in_ready = 0, no extra sample accepted. Release → a single handshake, then the next accept 1 cycle later.
- Flush mid-MAC: flush at E3 → no out_valid, history = 0, in_ready = 1 next cycle. hist_wr during MAC is ignored (verify by readback via passthrough using b1 = 0x7FFF).
